// File: rtl/grid_io_param_bank.sv
// grid_io_param_bank
//   Perimeter I/O grid tile. It holds NUM_SUBTILES GPIO subtiles that share one
//   serial configuration chain. Each subtile has three configuration bits:
//   output enable, registered output and synchronised input. The pad is split
//   into IN/OUT/OE signals because the tristate buffer sits in the pad ring.
//
// Ports
//   prog_clk            single clock for the chain, the registers and the synchronisers
//   prog_reset          synchronous, active-low reset
//   cfg_done            1 = configuration complete; the chain is frozen
//   ccff_head           configuration chain serial input
//   ccff_tail           configuration chain serial output (chain[L-1])
//   top_pin_outpad      fabric -> pad data, one bit per subtile
//   top_pin_inpad       pad -> fabric data, one bit per subtile
//   gfpga_pad_GPIO_IN   pad input value
//   gfpga_pad_GPIO_OUT  pad output value
//   gfpga_pad_GPIO_OE   pad output enable (1 = drive)
module grid_io_param_bank #(
   parameter int unsigned NUM_SUBTILES = 8,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic                    prog_clk,
   input  logic                    prog_reset,
   input  logic                    cfg_done,
   input  logic                    ccff_head,
   output logic                    ccff_tail,
   input  logic [NUM_SUBTILES-1:0] top_pin_outpad,
   output logic [NUM_SUBTILES-1:0] top_pin_inpad,
   input  logic [NUM_SUBTILES-1:0] gfpga_pad_GPIO_IN,
   output logic [NUM_SUBTILES-1:0] gfpga_pad_GPIO_OUT,
   output logic [NUM_SUBTILES-1:0] gfpga_pad_GPIO_OE
);

   localparam int unsigned CFG_W   = 3;
   localparam int unsigned CHAIN_L = NUM_SUBTILES * CFG_W;

   // Bit positions inside one subtile's configuration field
   localparam int unsigned F_OE    = 0;
   localparam int unsigned F_OREG  = 1;
   localparam int unsigned F_ISYNC = 2;

   logic [CHAIN_L-1:0]      chain;
   logic [CHAIN_L-1:0]      active;
   logic                    cfg_valid;
   logic                    cfg_done_d;
   logic [NUM_SUBTILES-1:0] out_q;
   logic [NUM_SUBTILES-1:0] sync_q [SYNC_STAGES];

   always_ff @(posedge prog_clk) begin
      if (!prog_reset) begin
         chain      <= '0;
         active     <= '0;
         cfg_valid  <= 1'b0;
         cfg_done_d <= 1'b0;
         out_q      <= '0;
         for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '0;
         end
      end else begin
         if (!cfg_done) begin
            chain <= {chain[CHAIN_L-2:0], ccff_head};
         end

         cfg_done_d <= cfg_done;

         // The rising edge of cfg_done copies the chain into the active
         // configuration. Any low sample masks the pads but keeps the old
         // active configuration so that a reload can replace it later.
         if (cfg_done && !cfg_done_d) begin
            active    <= chain;
            cfg_valid <= 1'b1;
         end else if (!cfg_done) begin
            cfg_valid <= 1'b0;
         end

         // These keep running while the tile is unconfigured, so data is
         // already valid on the first live cycle.
         out_q     <= top_pin_outpad;
         sync_q[0] <= gfpga_pad_GPIO_IN;
         for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   assign ccff_tail = chain[CHAIN_L-1];

   always_comb begin
      gfpga_pad_GPIO_OE  = '0;
      gfpga_pad_GPIO_OUT = '0;
      top_pin_inpad      = '0;
      if (cfg_valid) begin
         for (int unsigned k = 0; k < NUM_SUBTILES; k++) begin
            gfpga_pad_GPIO_OE[k]  = active[k*CFG_W + F_OE];
            gfpga_pad_GPIO_OUT[k] = active[k*CFG_W + F_OREG] ? out_q[k]
                                                             : top_pin_outpad[k];
            top_pin_inpad[k]      = active[k*CFG_W + F_ISYNC] ? sync_q[SYNC_STAGES-1][k]
                                                              : gfpga_pad_GPIO_IN[k];
         end
      end
   end

endmodule

// File: tb/tb_grid_io_param_bank.sv
module tb_grid_io_param_bank;

   localparam int N  = 8;
   localparam int S  = 2;
   localparam int CW = 3;
   localparam int L  = N * CW;

   logic         prog_clk = 1'b0;
   logic         prog_reset;
   logic         cfg_done;
   logic         ccff_head;
   logic         ccff_tail;
   logic [N-1:0] top_pin_outpad;
   logic [N-1:0] top_pin_inpad;
   logic [N-1:0] gpio_in;
   logic [N-1:0] gpio_out;
   logic [N-1:0] gpio_oe;

   int checks   = 0;
   int failures = 0;

   grid_io_param_bank #(.NUM_SUBTILES(N), .SYNC_STAGES(S)) dut (
      .prog_clk           (prog_clk),
      .prog_reset         (prog_reset),
      .cfg_done           (cfg_done),
      .ccff_head          (ccff_head),
      .ccff_tail          (ccff_tail),
      .top_pin_outpad     (top_pin_outpad),
      .top_pin_inpad      (top_pin_inpad),
      .gfpga_pad_GPIO_IN  (gpio_in),
      .gfpga_pad_GPIO_OUT (gpio_out),
      .gfpga_pad_GPIO_OE  (gpio_oe)
   );

   always #5 prog_clk = ~prog_clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // hist[i] is the i-th most recently shifted configuration bit; it is what
   // chain position i holds. Missing entries mean 0 (cleared by reset).
   bit           hist[$];
   logic [N-1:0] in_hist[$];   // GPIO_IN samples, newest first
   logic [N-1:0] outpad_prev;
   logic [L-1:0] act_m;
   bit           done_prev;
   bit           valid_m;
   bit           started = 1'b0;

   function automatic bit hbit(input int i);
      return (i < hist.size()) ? hist[i] : 1'b0;
   endfunction

   always @(posedge prog_clk) begin
      if (!prog_reset) begin
         hist.delete();
         in_hist.delete();
         outpad_prev = '0;
         act_m       = '0;
         done_prev   = 1'b0;
         valid_m     = 1'b0;
         started     = 1'b1;
      end else begin
         if (cfg_done && !done_prev) begin
            for (int i = 0; i < L; i++) act_m[i] = hbit(i);
            valid_m = 1'b1;
         end else if (!cfg_done) begin
            valid_m = 1'b0;
         end
         done_prev = cfg_done;
         if (!cfg_done) begin
            hist.push_front(ccff_head);
            if (hist.size() > L) void'(hist.pop_back());
         end
         in_hist.push_front(gpio_in);
         if (in_hist.size() > S) void'(in_hist.pop_back());
         outpad_prev = top_pin_outpad;
      end
   end

   // Compare process: every falling edge, once a reset has been applied.
   always @(negedge prog_clk) begin
      if (started) begin
         logic [N-1:0] e_oe, e_out, e_in, synced;
         synced = (in_hist.size() >= S) ? in_hist[S-1] : '0;
         e_oe = '0; e_out = '0; e_in = '0;
         if (valid_m) begin
            for (int k = 0; k < N; k++) begin
               e_oe[k]  = act_m[k*CW];
               e_out[k] = act_m[k*CW+1] ? outpad_prev[k] : top_pin_outpad[k];
               e_in[k]  = act_m[k*CW+2] ? synced[k] : gpio_in[k];
            end
         end
         chk("model_tail",  {31'd0, ccff_tail}, {31'd0, hbit(L-1)});
         chk("model_oe",    {24'd0, gpio_oe}, {24'd0, e_oe});
         chk("model_out",   {24'd0, gpio_out}, {24'd0, e_out});
         chk("model_inpad", {24'd0, top_pin_inpad}, {24'd0, e_in});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge prog_clk);
      #2;
   endtask

   task automatic shift_word(input logic [L-1:0] w);
      cfg_done = 1'b0;
      for (int i = L-1; i >= 0; i--) begin
         ccff_head = w[i];
         tick();
      end
   endtask

   logic [L-1:0] pat;
   logic [L-1:0] cfg;

   initial begin
      // 1: reset with random inputs
      prog_reset     = 1'b0;
      cfg_done       = 1'($urandom);
      ccff_head      = 1'($urandom);
      top_pin_outpad = N'($urandom);
      gpio_in        = N'($urandom);
      tick();
      #1;
      chk("rst_oe",    {24'd0, gpio_oe}, 32'h0);
      chk("rst_out",   {24'd0, gpio_out}, 32'h0);
      chk("rst_inpad", {24'd0, top_pin_inpad}, 32'h0);
      chk("rst_tail",  {31'd0, ccff_tail}, 32'h0);
      prog_reset = 1'b1; cfg_done = 1'b0; ccff_head = 1'b0;
      top_pin_outpad = '0; gpio_in = '0;
      tick();

      // 2: chain transparency, first bit in emerges first
      pat = 24'hA5C33C;
      shift_word(pat);
      for (int j = 0; j < L; j++) begin
         #1;
         chk("shift_tail", {31'd0, ccff_tail}, {31'd0, pat[L-1-j]});
         ccff_head = 1'b0;
         tick();
      end

      // 3..5: subtile0 OE, subtile2 OE+OREG, subtile3 ISYNC, subtile4 plain
      cfg = '0;
      cfg[0*CW +: CW] = 3'b001;
      cfg[2*CW +: CW] = 3'b011;
      cfg[3*CW +: CW] = 3'b100;
      shift_word(cfg);
      cfg_done = 1'b1;
      tick();
      #1;
      chk("load_oe", {24'd0, gpio_oe}, 32'h05);
      chk("out0_before", {31'd0, gpio_out[0]}, 32'h0);
      top_pin_outpad[0] = 1'b1;
      #1;
      chk("out0_comb", {31'd0, gpio_out[0]}, 32'h1);

      top_pin_outpad[2] = 1'b1;
      #1;
      chk("out2_pre", {31'd0, gpio_out[2]}, 32'h0);
      tick();
      top_pin_outpad[2] = 1'b0;
      #1;
      chk("out2_pulse", {31'd0, gpio_out[2]}, 32'h1);
      tick();
      #1;
      chk("out2_after", {31'd0, gpio_out[2]}, 32'h0);

      gpio_in[3] = 1'b1; gpio_in[4] = 1'b1;
      #1;
      chk("in4_comb", {31'd0, top_pin_inpad[4]}, 32'h1);
      chk("in3_e0",   {31'd0, top_pin_inpad[3]}, 32'h0);
      tick();
      #1;
      chk("in3_e1", {31'd0, top_pin_inpad[3]}, 32'h0);
      tick();
      #1;
      chk("in3_e2", {31'd0, top_pin_inpad[3]}, 32'h1);

      // 6: drop cfg_done -> masked
      cfg_done = 1'b0;
      tick();
      #1;
      chk("mask_oe",    {24'd0, gpio_oe}, 32'h0);
      chk("mask_out",   {24'd0, gpio_out}, 32'h0);
      chk("mask_inpad", {24'd0, top_pin_inpad}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         ccff_head = 1'b1;
         tick();
      end
      prog_reset = 1'b0;
      tick();
      #1;
      chk("midrst_tail", {31'd0, ccff_tail}, 32'h0);
      prog_reset = 1'b1;
      shift_word(cfg);
      cfg_done = 1'b1;
      tick();
      #1;
      chk("reload_oe",    {24'd0, gpio_oe}, 32'h05);
      chk("reload_inpad", {24'd0, top_pin_inpad & 8'h18}, 32'h18);

      // cfg_done held high through reset: load of an all-zero chain afterwards
      prog_reset = 1'b0;
      tick();
      prog_reset = 1'b1;
      top_pin_outpad = '1;
      tick();
      #1;
      chk("held_done_oe",  {24'd0, gpio_oe}, 32'h0);
      chk("held_done_out", {24'd0, gpio_out}, 32'hFF);

      // Randomised phase, checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         prog_reset = ($urandom_range(0, 99) >= 3);
         if ($urandom_range(0, 29) == 0) cfg_done = ~cfg_done;
         ccff_head      = 1'($urandom);
         top_pin_outpad = N'($urandom);
         gpio_in        = N'($urandom);
         tick();
      end

      #5;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
